// File: rtl/harp_pkg.sv
// Shared widths, the event record and the round-robin picker for the laser-harp voice scheduler.
// Pure declarations: no latency, no backpressure.
package harp_pkg;

    localparam int NUM_STRINGS_DFLT = 8;
    localparam int NUM_VOICES_DFLT  = 4;
    localparam int SW               = $clog2(NUM_STRINGS_DFLT);
    localparam int VW               = $clog2(NUM_VOICES_DFLT);

    // Upper bound on beams the round-robin picker can scan.
    localparam int MAX_STRINGS      = 32;
    localparam int MAX_SW           = $clog2(MAX_STRINGS);

    typedef struct packed {
        logic          on;
        logic [SW-1:0] str;
        logic [VW-1:0] voice;
    } evt_t;

    // First set bit of req at or above ptr, wrapping at n (n need not be a power of two).
    function automatic int unsigned rr_first(input logic [MAX_STRINGS-1:0] req,
                                             input int unsigned            ptr,
                                             input int unsigned            n);
        int unsigned idx;
        logic        found;
        rr_first = 0;
        found    = 1'b0;
        for (int unsigned k = 0; k < MAX_STRINGS; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !found && req[idx[MAX_SW-1:0]]) begin
                found    = 1'b1;
                rr_first = idx;
            end
        end
    endfunction

endpackage

// File: rtl/beam_debounce.sv
// One beam: 2-flop synchroniser, stable-count debounce and break/release pulses.
// Latency 2 + DEBOUNCE_CYCLES cycles from raw edge to o_state change; no backpressure.
module beam_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_beam_n,
    output logic o_state,
    output logic o_break,
    output logic o_release
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_state;
    logic [CW-1:0] r_cnt;

    logic          w_differ;
    logic          w_toggle;

    // Beam is active-low at the photodiode; state is 1 while broken.
    assign w_differ = (~r_sync2) != r_state;
    assign w_toggle = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_beam_n;
            r_sync2 <= r_sync1;
            if (w_toggle) begin
                r_state <= ~r_state;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt   <= r_cnt + CW'(1);
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    assign o_state   = r_state;
    assign o_break   = w_toggle & ~r_state;
    assign o_release = w_toggle &  r_state;

endmodule

// File: rtl/harp_voice_scheduler.sv
// Turns debounced beam edges into note-on/off events with voice allocation and round-robin arbitration.
// Grant 1 cycle after a debounced edge; event held until evt_ready, next grant the cycle after acceptance.
module harp_voice_scheduler
    import harp_pkg::*;
#(
    parameter int NUM_STRINGS     = NUM_STRINGS_DFLT,
    parameter int NUM_VOICES      = NUM_VOICES_DFLT,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_STRINGS-1:0] beam_n,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic                   evt_on,
    output logic [SW-1:0]          evt_string,
    output logic [VW-1:0]          evt_voice,
    output logic [NUM_VOICES-1:0]  voice_active,
    output logic [NUM_STRINGS-1:0] string_state
);

    logic [NUM_STRINGS-1:0] w_state;
    logic [NUM_STRINGS-1:0] w_break;
    logic [NUM_STRINGS-1:0] w_release;

    for (genvar g = 0; g < NUM_STRINGS; g++) begin : g_beam
        beam_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_beam (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_beam_n  (beam_n[g]),
            .o_state   (w_state[g]),
            .o_break   (w_break[g]),
            .o_release (w_release[g])
        );
    end

    logic [NUM_STRINGS-1:0] r_pend_on;
    logic [NUM_STRINGS-1:0] r_pend_off;
    logic [NUM_VOICES-1:0]  r_voice_act;
    logic [SW-1:0]          r_voice_str [NUM_VOICES];
    logic [SW-1:0]          r_rr_ptr;
    logic                   r_evt_vld;
    evt_t                   r_evt;

    logic                   w_any_free;
    logic [NUM_STRINGS-1:0] w_elig;
    logic [MAX_STRINGS-1:0] w_req;
    logic                   w_do_grant;
    logic [SW-1:0]          w_gnt_idx;
    logic                   w_gnt_off;
    logic [VW-1:0]          w_free_v;
    logic [VW-1:0]          w_off_v;
    logic [SW-1:0]          w_rr_nxt;
    logic [NUM_STRINGS-1:0] w_pend_on_nxt;
    logic [NUM_STRINGS-1:0] w_pend_off_nxt;

    assign w_any_free = ~&r_voice_act;
    assign w_elig     = r_pend_off | (r_pend_on & {NUM_STRINGS{w_any_free}});
    assign w_do_grant = !r_evt_vld && (|w_elig);
    assign w_gnt_idx  = SW'(rr_first(w_req, 32'(r_rr_ptr), NUM_STRINGS));
    // A pending release always beats a pending pluck on the same string.
    assign w_gnt_off  = r_pend_off[w_gnt_idx];
    assign w_rr_nxt   = (w_gnt_idx == SW'(NUM_STRINGS - 1)) ? '0 : w_gnt_idx + SW'(1);

    always_comb begin
        w_req                    = '0;
        w_req[NUM_STRINGS-1:0]   = w_elig;
    end

    always_comb begin
        w_free_v = '0;
        w_off_v  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!r_voice_act[v]) begin
                w_free_v = VW'(v);
            end
            if (r_voice_act[v] && (r_voice_str[v] == w_gnt_idx)) begin
                w_off_v = VW'(v);
            end
        end
    end

    // Grant clears first so a same-cycle edge re-arms the flag; a release
    // against a still-pending pluck cancels it rather than queueing a note-off.
    always_comb begin
        w_pend_on_nxt  = r_pend_on;
        w_pend_off_nxt = r_pend_off;
        if (w_do_grant) begin
            if (w_gnt_off) begin
                w_pend_off_nxt[w_gnt_idx] = 1'b0;
            end else begin
                w_pend_on_nxt[w_gnt_idx]  = 1'b0;
            end
        end
        for (int i = 0; i < NUM_STRINGS; i++) begin
            if (w_break[i]) begin
                w_pend_on_nxt[i] = 1'b1;
            end
            if (w_release[i]) begin
                if (w_pend_on_nxt[i]) begin
                    w_pend_on_nxt[i]  = 1'b0;
                end else begin
                    w_pend_off_nxt[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pend_on   <= '0;
            r_pend_off  <= '0;
            r_voice_act <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_voice_str[v] <= '0;
            end
            r_rr_ptr    <= '0;
            r_evt_vld   <= 1'b0;
            r_evt       <= '0;
        end else begin
            r_pend_on  <= w_pend_on_nxt;
            r_pend_off <= w_pend_off_nxt;
            if (w_do_grant) begin
                r_evt_vld  <= 1'b1;
                r_evt.on   <= !w_gnt_off;
                r_evt.str  <= w_gnt_idx;
                r_rr_ptr   <= w_rr_nxt;
                if (w_gnt_off) begin
                    r_evt.voice            <= w_off_v;
                    r_voice_act[w_off_v]   <= 1'b0;
                end else begin
                    r_evt.voice            <= w_free_v;
                    r_voice_act[w_free_v]  <= 1'b1;
                    r_voice_str[w_free_v]  <= w_gnt_idx;
                end
            end else if (r_evt_vld && evt_ready) begin
                r_evt_vld <= 1'b0;
            end
        end
    end

    assign evt_valid    = r_evt_vld;
    assign evt_on       = r_evt.on;
    assign evt_string   = r_evt.str;
    assign evt_voice    = r_evt.voice;
    assign voice_active = r_voice_act;
    assign string_state = w_state;

endmodule

// File: tb/tb_harp_voice_scheduler.sv
// Directed bench for harp_voice_scheduler with a behavioural event model compared every cycle.
module tb_harp_voice_scheduler;
    import harp_pkg::*;

    localparam int NS = 8;
    localparam int NV = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NS-1:0] beam_n;
    logic          evt_valid;
    logic          evt_ready;
    logic          evt_on;
    logic [SW-1:0] evt_string;
    logic [VW-1:0] evt_voice;
    logic [NV-1:0] voice_active;
    logic [NS-1:0] string_state;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit cmp_en = 1'b0;

    int lg_on[$];
    int lg_str[$];
    int lg_v[$];
    int lg_cyc[$];

    harp_voice_scheduler #(
        .NUM_STRINGS     (NS),
        .NUM_VOICES      (NV),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .beam_n       (beam_n),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_on       (evt_on),
        .evt_string   (evt_string),
        .evt_voice    (evt_voice),
        .voice_active (voice_active),
        .string_state (string_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_ev(input string nm, input int idx, input int on, input int st, input int v);
        if (idx >= lg_on.size()) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: event %0d missing, only %0d logged", nm, idx, lg_on.size());
        end else begin
            chk({nm, ".on"},    lg_on[idx],  on);
            chk({nm, ".str"},   lg_str[idx], st);
            chk({nm, ".voice"}, lg_v[idx],   v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural model: raw beam delayed two cycles, accepted after D consecutive
    // disagreeing cycles; pending notes served round-robin from the string after the last grant.
    logic [NS-1:0] m_d1 = '1, m_d2 = '1, m_st = '0, m_pon = '0, m_poff = '0;
    int            m_run [NS];
    logic [NV-1:0] m_vact = '0;
    int            m_vown [NV];
    int            m_ptr = 0;
    bit            m_vld = 0, m_on = 0;
    int            m_str = 0, m_voice = 0;

    always @(posedge clk) begin
        bit            g, goff;
        int            gs, gv, s;
        logic [NS-1:0] brk, rel;
        if (!reset_n) begin
            m_d1 = '1; m_d2 = '1; m_st = '0; m_pon = '0; m_poff = '0;
            m_vact = '0; m_ptr = 0; m_vld = 0; m_on = 0; m_str = 0; m_voice = 0;
            for (int i = 0; i < NS; i++) m_run[i] = 0;
            for (int v = 0; v < NV; v++) m_vown[v] = 0;
        end else begin
            g = 0; gs = 0;
            if (!m_vld) begin
                for (int k = 0; k < NS; k++) begin
                    s = (m_ptr + k) % NS;
                    if (!g && (m_poff[s] || (m_pon[s] && m_vact != '1))) begin
                        g = 1; gs = s;
                    end
                end
            end
            brk = '0; rel = '0;
            for (int i = 0; i < NS; i++) begin
                if ((!m_d2[i]) != m_st[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_run[i] = 0;
                        if (m_st[i]) rel[i] = 1'b1; else brk[i] = 1'b1;
                        m_st[i] = !m_st[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = beam_n;
            if (m_vld && evt_ready) begin
                m_vld = 0;
            end else if (g) begin
                goff = m_poff[gs];
                m_vld = 1; m_on = !goff; m_str = gs;
                gv = -1;
                if (goff) begin
                    m_poff[gs] = 1'b0;
                    for (int v = 0; v < NV; v++)
                        if (gv < 0 && m_vact[v] && m_vown[v] == gs) gv = v;
                    if (gv < 0) gv = 0;
                    m_vact[gv] = 1'b0;
                end else begin
                    m_pon[gs] = 1'b0;
                    for (int v = 0; v < NV; v++)
                        if (gv < 0 && !m_vact[v]) gv = v;
                    m_vact[gv] = 1'b1;
                    m_vown[gv] = gs;
                end
                m_voice = gv;
                m_ptr = (gs + 1) % NS;
            end
            for (int i = 0; i < NS; i++) begin
                if (brk[i]) m_pon[i] = 1'b1;
                if (rel[i]) begin
                    if (m_pon[i]) m_pon[i] = 1'b0; else m_poff[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_valid", evt_valid, m_vld);
            if (m_vld) begin
                chk("cmp_on",     evt_on,          m_on);
                chk("cmp_string", 32'(evt_string), m_str);
                chk("cmp_voice",  32'(evt_voice),  m_voice);
            end
            chk("cmp_voice_active", 32'(voice_active), 32'(m_vact));
            chk("cmp_string_state", 32'(string_state), 32'(m_st));
            if (evt_valid && evt_ready) begin
                lg_on.push_back(int'(evt_on));
                lg_str.push_back(int'(evt_string));
                lg_v.push_back(int'(evt_voice));
                lg_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        int base, cnt;
        reset_n   = 1'b0;
        beam_n    = '1;
        evt_ready = 1'b1;
        tick(3);
        chk("rst_valid",        evt_valid,           0);
        chk("rst_on",           evt_on,              0);
        chk("rst_string",       32'(evt_string),     0);
        chk("rst_voice",        32'(evt_voice),      0);
        chk("rst_voice_active", 32'(voice_active),   0);
        chk("rst_string_state", 32'(string_state),   0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Pluck string 2: event becomes visible exactly 7 cycles after the edge.
        beam_n[2] = 1'b0;
        tick(6);
        chk("t1_valid_c6", evt_valid, 0);
        chk("t1_state_c6", string_state[2], 1);
        tick(1);
        chk("t1_valid_c7", evt_valid, 1);
        chk("t1_on",       evt_on, 1);
        chk("t1_string",   32'(evt_string), 2);
        chk("t1_voice",    32'(evt_voice), 0);
        chk("t1_vact",     32'(voice_active), 32'h1);
        tick(2);

        // Release string 2.
        beam_n[2] = 1'b1;
        tick(7);
        chk("t2_valid",  evt_valid, 1);
        chk("t2_on",     evt_on, 0);
        chk("t2_string", 32'(evt_string), 2);
        chk("t2_voice",  32'(evt_voice), 0);
        chk("t2_vact",   32'(voice_active), 0);
        tick(2);

        // Glitch shorter than the debounce window on string 5.
        base = lg_on.size();
        beam_n[5] = 1'b0;
        tick(3);
        beam_n[5] = 1'b1;
        tick(10);
        chk("glitch_state", string_state[5], 0);
        chk("glitch_no_evt", lg_on.size(), base);

        // Pluck and release string 3 to move the round-robin pointer to 4.
        beam_n[3] = 1'b0;
        tick(9);
        beam_n[3] = 1'b1;
        tick(9);

        // Beams 1, 3, 6 break together; scan starts at 4.
        base = lg_on.size();
        beam_n[1] = 1'b0; beam_n[3] = 1'b0; beam_n[6] = 1'b0;
        tick(13);
        chk_ev("t3_ev0", base,     1, 6, 0);
        chk_ev("t3_ev1", base + 1, 1, 1, 1);
        chk_ev("t3_ev2", base + 2, 1, 3, 2);
        if (lg_cyc.size() >= base + 3) begin
            chk("t3_gap01", lg_cyc[base + 1] - lg_cyc[base],     2);
            chk("t3_gap12", lg_cyc[base + 2] - lg_cyc[base + 1], 2);
        end
        beam_n[1] = 1'b1; beam_n[3] = 1'b1; beam_n[6] = 1'b1;
        tick(14);

        // Voice exhaustion: four voices used, string 5 waits for a release.
        base = lg_on.size();
        beam_n[3:0] = 4'h0;
        tick(14);
        beam_n[5] = 1'b0;
        tick(12);
        chk("t4_count4", lg_on.size(), base + 4);
        chk("t4_vact_full", 32'(voice_active), 32'hF);
        chk_ev("t4_on0", base,     1, 0, 0);
        chk_ev("t4_on3", base + 3, 1, 3, 3);
        beam_n[0] = 1'b1;
        tick(12);
        chk_ev("t4_off0", base + 4, 0, 0, 0);
        chk_ev("t4_on5",  base + 5, 1, 5, 0);
        beam_n = '1;
        tick(16);

        // Backpressure with a cancelled pluck on string 4 during the stall.
        base = lg_on.size();
        evt_ready = 1'b0;
        beam_n[7] = 1'b0;
        tick(7);
        chk("t5_valid",  evt_valid, 1);
        chk("t5_string", 32'(evt_string), 7);
        beam_n[4] = 1'b0;
        tick(8);
        beam_n[4] = 1'b1;
        tick(12);
        chk("t5_hold_valid",  evt_valid, 1);
        chk("t5_hold_on",     evt_on, 1);
        chk("t5_hold_string", 32'(evt_string), 7);
        chk("t5_hold_voice",  32'(evt_voice), 0);
        chk("t5_state4",      string_state[4], 0);
        evt_ready = 1'b1;
        tick(12);
        chk_ev("t5_ev7", base, 1, 7, 0);
        cnt = 0;
        for (int k = base; k < lg_str.size(); k++) if (lg_str[k] == 4) cnt++;
        chk("t5_no_evt_s4", cnt, 0);
        beam_n[7] = 1'b1;
        tick(10);

        // Reset while an event is held and two voices are active.
        beam_n[0] = 1'b0;
        tick(9);
        evt_ready = 1'b0;
        beam_n[1] = 1'b0;
        tick(7);
        chk("t6_valid_pre", evt_valid, 1);
        chk("t6_vact_pre",  32'(voice_active), 32'h3);
        reset_n = 1'b0;
        beam_n  = '1;
        tick(1);
        chk("t6_valid",  evt_valid, 0);
        chk("t6_on",     evt_on, 0);
        chk("t6_string", 32'(evt_string), 0);
        chk("t6_voice",  32'(evt_voice), 0);
        chk("t6_vact",   32'(voice_active), 0);
        chk("t6_sstate", 32'(string_state), 0);
        reset_n   = 1'b1;
        evt_ready = 1'b1;
        base = lg_on.size();
        tick(20);
        chk("t6_no_evt", lg_on.size(), base);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/harp_voice_scheduler.md
Name: harp_voice_scheduler

Overview:
- Sequences the eight photodiode beam inputs of the laser harp into note-on/note-off events for the audio synthesis path.
- Synchronises and debounces each beam and detects break and release edges.
- Allocates one of NUM_VOICES synth voices per broken beam and round-robin arbitrates pending events onto a single valid/ready event port.
- Sits between the photodiode conduit and the voice mixer feeding the audio core.

Parameters:
NUM_STRINGS, 8, number of beams/strings (event string index width SW = clog2(NUM_STRINGS))
NUM_VOICES, 4, number of synth voices (voice index width VW = clog2(NUM_VOICES))
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a beam change is accepted (1 ms at 50 MHz)

Ports:
clk  input  1  system clock, all logic rising-edge
reset_n  input  1  reset, synchronous, active-low
beam_n  input  NUM_STRINGS  raw photodiode levels, asynchronous; 0 = beam broken
evt_valid  output  1  event available
evt_ready  input  1  consumer accepts event when high with evt_valid
evt_on  output  1  1 = note-on, 0 = note-off
evt_string  output  SW  string index of event
evt_voice  output  VW  voice allocated (on) or released (off)
voice_active  output  NUM_VOICES  voice currently allocated
string_state  output  NUM_STRINGS  debounced state, 1 = broken

Behaviour:
- Reset, on the clk edge with reset_n=0:
  - All outputs 0.
  - Synchronisers preset to 1 (beam intact).
  - Debounce counters 0; pend_on/pend_off 0; voice table cleared; RR pointer 0.
  - Reset mid-handshake drops the event; no note-off is issued for previously active voices.
- Sync: 2-flop synchroniser per beam; debounce compares only the synchronised value.
- Debounce, per string:
  - Counter increments while the synced value differs from string_state and clears when it is equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and still differs, string_state toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes string_state.
- Edge flags:
  - string_state 0->1 sets pend_on[i].
  - 1->0 sets pend_off[i], unless pend_on[i] is still set: then pend_on[i] is cleared and no event is produced (cancelled pluck).
- Eligibility: string i is eligible if pend_off[i], or if pend_on[i] and at least one voice is free.
  - pend_on waiting for a free voice stays pending with no timeout.
- Arbiter, evaluated only while evt_valid=0:
  - Picks the first eligible string scanning upward from rr_ptr, wrapping.
  - On grant: evt_on/evt_string/evt_voice register, evt_valid=1 next cycle, the granted pend bit clears, rr_ptr = granted+1 mod NUM_STRINGS.
  - Note-on takes the lowest-index free voice; voice_active[v] sets and voice_string[v]=i at grant.
  - Note-off releases the voice whose voice_string matches i; voice_active[v] clears at grant.
  - If a string has both pend_off and pend_on (fast re-pluck), off is served first.
- Handshake:
  - evt_valid and the payload stay stable until evt_valid&&evt_ready.
  - evt_valid drops the cycle after acceptance.
  - The next grant is evaluated in that cycle, so maximum throughput is 1 event per 2 cycles.
- Simultaneous events: an edge on string i in the grant cycle of string i sets the new flag; set wins over the grant clear.
- Latency: input edge to evt_valid = 2 (sync) + DEBOUNCE_CYCLES + 1 (grant) cycles when idle and a voice is free.
- Width rules: debounce counter width clog2(DEBOUNCE_CYCLES); rr_ptr wraps modulo NUM_STRINGS (non-power-of-2 allowed).

Decomposition:
- Package harp_pkg holds:
  - NUM_STRINGS and NUM_VOICES defaults, SW/VW localparams.
  - Event record (on, string, voice).
  - rr_first() round-robin priority function.
- Sub-module beam_debounce (sync + debounce + edge pulses), instantiated NUM_STRINGS times.
- The scheduler holds the pend flags, voice table, arbiter and output register.

Test Plan (DEBOUNCE_CYCLES=4, evt_ready=1 unless stated):
1. Debounce/latency: beam_n[2] 1->0 held → evt_valid at cycle 7 with on=1, string=2, voice=0; voice_active=0001. A 3-cycle low glitch on beam_n[5] → no event, string_state[5]=0.
2. Release: beam_n[2] back to 1 → off event string=2 voice=0; voice_active=0000.
3. Round-robin: beams 1, 3 and 6 break in the same cycle, rr_ptr=4 → order 6, 1, 3 with voices 0, 1, 2; events 2 cycles apart.
4. Voice exhaustion: break 5 strings → 4 on-events (voices 0-3), string 5 pending. Release string 0 → off(0, v0), then on(5, v0).
5. Backpressure and cancel: hold evt_ready=0 for 20 cycles → payload stable. Break then release string 4 before its grant → no on/off events for 4.
6. Reset mid-operation: reset_n=0 for 1 cycle while evt_valid=1 with 2 voices active → next cycle all outputs 0; no spurious events afterwards while beams stay intact.
